// File: rtl/apb_rr_master_arb.sv
// Round-robin APB master: accept-to-response 3 cycles plus slave wait states, one transfer per 3 cycles peak.
// Backpressure: req_ready_o only in IDLE, pready_i stretches ACCESS; optional watchdog via APB_ARB_TIMEOUT_EN.
module apb_rr_master_arb #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumReq-1:0]               req_valid_i,
  output logic [NumReq-1:0]               req_ready_o,
  input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
  input  logic [NumReq-1:0]               req_write_i,
  input  logic [NumReq*DataWidth-1:0]     req_wdata_i,
  input  logic [NumReq*DataWidth/8-1:0]   req_strb_i,
  output logic [NumReq-1:0]               rsp_valid_o,
  output logic [DataWidth-1:0]            rsp_rdata_o,
  output logic                            rsp_err_o,
  output logic [AddrWidth-1:0]            paddr_o,
  output logic                            pwrite_o,
  output logic [DataWidth-1:0]            pwdata_o,
  output logic [DataWidth/8-1:0]          pstrb_o,
  output logic                            psel_o,
  output logic                            penable_o,
  input  logic [DataWidth-1:0]            prdata_i,
  input  logic                            pready_i,
  input  logic                            pslverr_i
);

  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned StrbW = DataWidth / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] wdata;
    logic [StrbW-1:0]     strb;
  } apb_req_t;

  state_t              state_q, state_d;
  logic [IdxW-1:0]     rr_ptr_q;
  logic [IdxW-1:0]     idx_q;
  logic [IdxW-1:0]     grant_idx;
  logic [IdxW-1:0]     next_ptr;
  logic                grant_found;
  apb_req_t            req_q;
  apb_req_t            grant_req;
  logic [NumReq-1:0]   rsp_valid_q;
  logic [DataWidth-1:0] rsp_rdata_q;
  logic                rsp_err_q;
  logic                xfer_abort;
  logic                xfer_done;

  logic [AddrWidth-1:0] addr_a  [NumReq];
  logic [DataWidth-1:0] wdata_a [NumReq];
  logic [StrbW-1:0]     strb_a  [NumReq];

  for (genvar g = 0; g < NumReq; g++) begin : g_unpack
    assign addr_a[g]  = req_addr_i[g*AddrWidth +: AddrWidth];
    assign wdata_a[g] = req_wdata_i[g*DataWidth +: DataWidth];
    assign strb_a[g]  = req_strb_i[g*StrbW +: StrbW];
  end

  // First valid requester at or above the pointer, wrapping at NumReq.
  always_comb begin
    int unsigned      cand;
    logic [IdxW-1:0]  cand_idx;
    cand        = 0;
    cand_idx    = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand     = (32'(rr_ptr_q) + k) % NumReq;
      cand_idx = IdxW'(cand);
      if (!grant_found && req_valid_i[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    grant_req.addr  = addr_a[grant_idx];
    grant_req.write = req_write_i[grant_idx];
    grant_req.wdata = wdata_a[grant_idx];
    grant_req.strb  = strb_a[grant_idx];
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  logic [CntW-1:0] wd_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wd_cnt_q <= '0;
    end else if (state_q == SETUP) begin
      wd_cnt_q <= '0;
    end else if (state_q == ACCESS && !pready_i) begin
      wd_cnt_q <= wd_cnt_q + 1'b1;
    end
  end

  // Abort on the stalled cycle that would bring the count to the limit; pready_i wins a tie.
  assign xfer_abort = (state_q == ACCESS) && !pready_i &&
                      (wd_cnt_q == CntW'(TimeoutCycles - 1));
`else
  assign xfer_abort = (TimeoutCycles == 0) ? 1'b0 : 1'b0;
`endif

  assign xfer_done = (state_q == ACCESS) && (pready_i || xfer_abort);
  assign next_ptr  = (idx_q == IdxW'(NumReq - 1)) ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready_o[grant_idx] = 1'b1;
          state_d                = SETUP;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS:  if (xfer_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      req_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= '0;
      if (state_q == IDLE && grant_found) begin
        req_q <= grant_req;
        idx_q <= grant_idx;
      end
      if (xfer_done) begin
        rsp_valid_q[idx_q] <= 1'b1;
        rsp_rdata_q        <= (xfer_abort || req_q.write) ? '0 : prdata_i;
        rsp_err_q          <= xfer_abort || pslverr_i;
        rr_ptr_q           <= next_ptr;
      end
    end
  end

  assign psel_o      = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o   = (state_q == ACCESS);
  assign paddr_o     = req_q.addr;
  assign pwrite_o    = req_q.write;
  assign pwdata_o    = req_q.wdata;
  assign pstrb_o     = req_q.strb;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_master_arb.sv
// Bench for apb_rr_master_arb: vector table, reset/timeout sequences, and a random run against a
// transaction-level arbitration model.
module tb_apb_rr_master_arb;

  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic               rst_ni;
  logic [NR-1:0]      req_valid_i;
  logic [NR-1:0]      req_ready_o;
  logic [NR*AW-1:0]   req_addr_i;
  logic [NR-1:0]      req_write_i;
  logic [NR*DW-1:0]   req_wdata_i;
  logic [NR*SW-1:0]   req_strb_i;
  logic [NR-1:0]      rsp_valid_o;
  logic [DW-1:0]      rsp_rdata_o;
  logic               rsp_err_o;
  logic [AW-1:0]      paddr_o;
  logic               pwrite_o;
  logic [DW-1:0]      pwdata_o;
  logic [SW-1:0]      pstrb_o;
  logic               psel_o;
  logic               penable_o;
  logic [DW-1:0]      prdata_i;
  logic               pready_i;
  logic               pslverr_i;

  apb_rr_master_arb #(
    .NumReq(NR), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i), .req_strb_i(req_strb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .paddr_o(paddr_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .psel_o(psel_o), .penable_o(penable_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  logic [AW-1:0] s_addr  [NR];
  logic [DW-1:0] s_wdata [NR];
  logic [SW-1:0] s_strb  [NR];
  logic [NR-1:0] s_write;

  task automatic apply_req(input logic [NR-1:0] v);
    req_valid_i = v;
    req_write_i = s_write;
    for (int i = 0; i < NR; i++) begin
      req_addr_i[i*AW +: AW]  = s_addr[i];
      req_wdata_i[i*DW +: DW] = s_wdata[i];
      req_strb_i[i*SW +: SW]  = s_strb[i];
    end
  endtask

  task automatic randomize_reqs();
    for (int i = 0; i < NR; i++) begin
      s_addr[i]  = $urandom;
      s_wdata[i] = $urandom;
      s_strb[i]  = SW'($urandom);
      s_write[i] = 1'($urandom);
    end
  endtask

  task automatic apply_reset();
    rst_ni    = 1'b0;
    pready_i  = 1'b0;
    pslverr_i = 1'b0;
    apply_req('0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            wait_n;
    logic          err;
    logic [DW-1:0] rdata;
    int            exp_idx;
  } vec_t;

  vec_t tbl[12];

  // Random-run model state: arbitration pointer and the transfer/response schedule.
  int            ptr_m, acc_c, done_c, rsp_c, cur_idx, rsp_idx, win, acc_n;
  bit            act;
  logic          cur_write, rsp_err;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata, rsp_rdata;
  logic [SW-1:0] cur_strb;
  logic [NR-1:0] vmask, exp_rdy, exp_rsp;

  initial begin
    tbl[0]  = '{4'b1111, 1'b0, 32'h0000_1000, 32'h0,         4'hF, 0, 1'b0, 32'h1111_0000, 0};
    tbl[1]  = '{4'b1111, 1'b1, 32'h0000_1004, 32'h2222_2222, 4'h3, 0, 1'b0, 32'h0,         1};
    tbl[2]  = '{4'b1111, 1'b0, 32'h0000_1008, 32'h0,         4'hF, 0, 1'b0, 32'h3333_0000, 2};
    tbl[3]  = '{4'b1111, 1'b1, 32'h0000_100C, 32'h4444_4444, 4'hC, 0, 1'b0, 32'h0,         3};
    tbl[4]  = '{4'b1111, 1'b0, 32'h0000_1010, 32'h0,         4'hF, 0, 1'b0, 32'h5555_0000, 0};
    tbl[5]  = '{4'b0100, 1'b0, 32'h0000_0040, 32'h0,         4'hF, 0, 1'b0, 32'hCAFE_0001, 2};
    tbl[6]  = '{4'b1001, 1'b0, 32'h0000_2000, 32'h0,         4'hF, 1, 1'b0, 32'h0000_0066, 3};
    tbl[7]  = '{4'b1001, 1'b1, 32'h0000_2004, 32'h0000_0077, 4'hF, 2, 1'b0, 32'h0,         0};
    tbl[8]  = '{4'b1001, 1'b0, 32'h0000_2008, 32'h0,         4'hF, 0, 1'b1, 32'h0000_0088, 3};
    tbl[9]  = '{4'b0010, 1'b1, 32'h0000_3000, 32'hA5A5_A5A5, 4'h5, 5, 1'b1, 32'h0,         1};
    tbl[10] = '{4'b0011, 1'b0, 32'h0000_3004, 32'h0,         4'hF, 0, 1'b0, 32'h0000_0099, 0};
    tbl[11] = '{4'b0011, 1'b1, 32'h0000_3008, 32'h0000_00BB, 4'h8, 2, 1'b0, 32'h0,         1};

    rst_ni = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
    randomize_reqs();
    apply_req('0);
    repeat (2) @(posedge clk_i);
    #5;
    chk("reset psel", psel_o, 0);
    chk("reset penable", penable_o, 0);
    chk("reset rsp_valid", rsp_valid_o, 0);
    chk("reset rsp_err", rsp_err_o, 0);
    chk("reset rsp_rdata", rsp_rdata_o, 0);
    chk("reset paddr", paddr_o, 0);
    chk("reset pwdata", pwdata_o, 0);
    chk("reset pstrb", pstrb_o, 0);
    chk("reset pwrite", pwrite_o, 0);
    rst_ni = 1'b1;

    @(posedge clk_i); #1;
    for (int r = 0; r < 12; r++) begin
      vec_t t;
      t = tbl[r];
      for (int i = 0; i < NR; i++) begin
        s_addr[i]  = 32'hDEAD_0000 | i;
        s_wdata[i] = 32'hFEED_0000 | i;
        s_strb[i]  = SW'(i);
        s_write[i] = ~t.write;
      end
      s_addr[t.exp_idx]  = t.addr;
      s_wdata[t.exp_idx] = t.wdata;
      s_strb[t.exp_idx]  = t.strb;
      s_write[t.exp_idx] = t.write;
      apply_req(t.valid);
      pready_i = 1'b0;
      #4;
      chk($sformatf("row%0d ready", r), req_ready_o, 1 << t.exp_idx);
      chk($sformatf("row%0d accept psel", r), psel_o, 0);
      if (r > 0) begin
        chk($sformatf("row%0d prev rsp_valid", r), rsp_valid_o, 1 << tbl[r-1].exp_idx);
        chk($sformatf("row%0d prev rdata", r), rsp_rdata_o, tbl[r-1].write ? 32'h0 : tbl[r-1].rdata);
        chk($sformatf("row%0d prev err", r), rsp_err_o, tbl[r-1].err);
      end else begin
        chk("row0 rsp_valid", rsp_valid_o, 0);
      end
      @(posedge clk_i); #1;
      #4;
      chk($sformatf("row%0d setup psel", r), psel_o, 1);
      chk($sformatf("row%0d setup penable", r), penable_o, 0);
      chk($sformatf("row%0d setup ready", r), req_ready_o, 0);
      chk($sformatf("row%0d setup paddr", r), paddr_o, t.addr);
      chk($sformatf("row%0d setup pwrite", r), pwrite_o, t.write);
      for (int w = 0; w <= t.wait_n; w++) begin
        @(posedge clk_i); #1;
        pready_i  = (w == t.wait_n);
        prdata_i  = (w == t.wait_n) ? t.rdata : 32'hBAD0_0000;
        pslverr_i = (w == t.wait_n) ? t.err : 1'b1;
        #4;
        chk($sformatf("row%0d acc%0d psel", r, w), psel_o, 1);
        chk($sformatf("row%0d acc%0d penable", r, w), penable_o, 1);
        chk($sformatf("row%0d acc%0d ready", r, w), req_ready_o, 0);
        chk($sformatf("row%0d acc%0d rsp_valid", r, w), rsp_valid_o, 0);
        chk($sformatf("row%0d acc%0d paddr", r, w), paddr_o, t.addr);
        chk($sformatf("row%0d acc%0d pwdata", r, w), pwdata_o, t.wdata);
        chk($sformatf("row%0d acc%0d pstrb", r, w), pstrb_o, t.strb);
        chk($sformatf("row%0d acc%0d pwrite", r, w), pwrite_o, t.write);
      end
      @(posedge clk_i); #1;
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
    end
    apply_req('0);
    #4;
    chk("last rsp_valid", rsp_valid_o, 1 << tbl[11].exp_idx);
    chk("last rsp_err", rsp_err_o, tbl[11].err);
    chk("last psel", psel_o, 0);

    // Reset in the middle of ACCESS: transfer dropped, pointer back to 0.
    @(posedge clk_i); #1;
    randomize_reqs();
    apply_req(4'b1000);
    #4;
    chk("rst-seq ready", req_ready_o, 4'b1000);
    @(posedge clk_i); #1;
    apply_req('0);
    @(posedge clk_i); #1;
    #4;
    chk("rst-seq in access", penable_o, 1);
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    pready_i = 1'b1;
    #4;
    chk("rst-seq psel", psel_o, 0);
    chk("rst-seq penable", penable_o, 0);
    chk("rst-seq rsp_valid", rsp_valid_o, 0);
    chk("rst-seq paddr", paddr_o, 0);
    @(posedge clk_i); #1;
    rst_ni   = 1'b1;
    pready_i = 1'b0;
    apply_req(4'b1111);
    #4;
    chk("rst-seq first grant", req_ready_o, 4'b0001);
    chk("rst-seq no rsp", rsp_valid_o, 0);
    @(posedge clk_i); #1;
    apply_req('0);
    #4;
    chk("rst-seq no rsp 2", rsp_valid_o, 0);
    chk("rst-seq setup", psel_o, 1);

`ifdef APB_ARB_TIMEOUT_EN
    apply_reset();
    randomize_reqs();
    apply_req(4'b0001);
    prdata_i = 32'hFFFF_FFFF;
    #4;
    chk("to ready", req_ready_o, 4'b0001);
    @(posedge clk_i); #1;
    apply_req('0);
    acc_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk_i); #5;
      if (psel_o && penable_o) acc_n++;
      else break;
    end
    chk("to access cycles", acc_n, TO);
    chk("to rsp_valid", rsp_valid_o, 4'b0001);
    chk("to rsp_err", rsp_err_o, 1);
    chk("to rsp_rdata", rsp_rdata_o, 0);
    apply_req(4'b0010);
    #1;
    chk("to next grant", req_ready_o, 4'b0010);
    @(posedge clk_i); #1;
    apply_req('0);
    #4;
    chk("to next setup", psel_o, 1);
`endif

    apply_reset();
    ptr_m = 0; act = 1'b0; rsp_c = -1; acc_c = 0; done_c = 0;
    cur_idx = 0; rsp_idx = 0;
    cur_write = 1'b0; cur_addr = '0; cur_wdata = '0; cur_strb = '0;
    rsp_rdata = '0; rsp_err = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk_i); #1;
      randomize_reqs();
      vmask = NR'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) vmask = '0;
      apply_req(vmask);
      prdata_i  = $urandom;
      pslverr_i = 1'($urandom);
      if (act && cyc >= acc_c + 2 && cyc < done_c) pready_i = (cyc == done_c - 1);
      else pready_i = 1'($urandom);
      if (act && cyc == done_c - 1) begin
        rsp_c     = done_c;
        rsp_idx   = cur_idx;
        rsp_rdata = cur_write ? '0 : prdata_i;
        rsp_err   = pslverr_i;
      end
      #4;
      exp_rsp = (cyc == rsp_c) ? NR'(1 << rsp_idx) : '0;
      chk("rnd rsp_valid", rsp_valid_o, exp_rsp);
      if (cyc == rsp_c) begin
        chk("rnd rsp_rdata", rsp_rdata_o, rsp_rdata);
        chk("rnd rsp_err", rsp_err_o, rsp_err);
      end
      if (act && cyc >= done_c) act = 1'b0;
      chk("rnd psel", psel_o, act && cyc > acc_c);
      chk("rnd penable", penable_o, act && cyc >= acc_c + 2);
      if (act && cyc > acc_c) begin
        chk("rnd paddr", paddr_o, cur_addr);
        chk("rnd pwrite", pwrite_o, cur_write);
        chk("rnd pwdata", pwdata_o, cur_wdata);
        chk("rnd pstrb", pstrb_o, cur_strb);
      end
      exp_rdy = '0;
      if (!act) begin
        win = -1;
        for (int k = 0; k < NR; k++) begin
          int idx;
          idx = (ptr_m + k) % NR;
          if (win < 0 && vmask[idx]) win = idx;
        end
        if (win >= 0) begin
          exp_rdy   = NR'(1 << win);
          act       = 1'b1;
          acc_c     = cyc;
          done_c    = cyc + 3 + int'($urandom_range(0, 3));
          cur_idx   = win;
          cur_addr  = s_addr[win];
          cur_write = s_write[win];
          cur_wdata = s_wdata[win];
          cur_strb  = s_strb[win];
          ptr_m     = (win + 1) % NR;
        end
      end
      chk("rnd ready", req_ready_o, exp_rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
